// File: rtl/mfsk_pkg.sv
// rtl/mfsk_pkg.sv - shared types, default configuration and tone helpers for mfsk_mod
package mfsk_pkg;

    localparam int unsigned DEF_ACC_W   = 8;
    localparam int unsigned DEF_BPS     = 1;
    localparam int unsigned DEF_SYM_DIV = 16;
    localparam int unsigned DEF_F0_INC  = 16;
    localparam int unsigned DEF_F_STEP  = 16;
    localparam int unsigned M           = 1 << DEF_BPS;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int unsigned tone_inc(input int unsigned sym,
                                             input int unsigned f0,
                                             input int unsigned step);
        return f0 + sym * step;
    endfunction

    // Highest tone must stay below half the accumulator range so the square wave never aliases.
    function automatic bit params_ok(input int unsigned acc_w,
                                     input int unsigned bps,
                                     input int unsigned sym_div,
                                     input int unsigned f0,
                                     input int unsigned step);
        if (acc_w < 2 || acc_w > 30 || bps < 1 || bps > 8) return 1'b0;
        if (sym_div < 2 || (sym_div % 2) != 0) return 1'b0;
        return (f0 + ((1 << bps) - 1) * step) < (1 << (acc_w - 1));
    endfunction

endpackage

// File: rtl/mfsk_nco.sv
// rtl/mfsk_nco.sv - phase accumulator with tone load and registered MSB output (MFSK_CONT_PHASE_EN selects continuous phase)
module mfsk_nco #(
    parameter int unsigned ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    input  logic             clear,
    input  logic [ACC_W-1:0] tone,
    output logic             shuchu
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] acc_load;
    logic [ACC_W-1:0] acc_step;

`ifdef MFSK_CONT_PHASE_EN
    assign base = acc;
`else
    assign base = '0;
`endif

    assign acc_load = base + tone;
    assign acc_step = acc + inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            inc    <= '0;
            shuchu <= 1'b0;
        end else if (load) begin
            inc    <= tone;
            acc    <= acc_load;
            shuchu <= acc_load[ACC_W-1];
        end else if (clear) begin
            acc    <= '0;
            shuchu <= 1'b0;
        end else if (advance) begin
            acc    <= acc_step;
            shuchu <= acc_step[ACC_W-1];
        end
    end

endmodule

// File: rtl/mfsk_mod.sv
// rtl/mfsk_mod.sv - M-ary FSK modulator top: symbol handshake, symbol timing FSM, NCO (MFSK_CONT_PHASE_EN enables CPFSK)
module mfsk_mod
    import mfsk_pkg::*;
#(
    parameter int unsigned ACC_W   = DEF_ACC_W,
    parameter int unsigned BPS     = DEF_BPS,
    parameter int unsigned SYM_DIV = DEF_SYM_DIV,
    parameter int unsigned F0_INC  = DEF_F0_INC,
    parameter int unsigned F_STEP  = DEF_F_STEP
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic [BPS-1:0] sym_data,
    input  logic           sym_valid,
    output logic           sym_ready,
    output logic           shuchu,
    output logic           clk1,
    output logic           busy,
    output logic           underrun
);

    localparam int unsigned CNT_W = (SYM_DIV > 2) ? $clog2(SYM_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SYM_DIV / 2);

    if (!params_ok(ACC_W, BPS, SYM_DIV, F0_INC, F_STEP)) begin : g_param_check
        $error("mfsk_mod: illegal parameter set");
    end

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             hold_valid;
    logic [BPS-1:0]   hold_sym;
    logic             load;
    logic             advance;
    logic             clear;
    logic [ACC_W-1:0] tone;

    assign sym_ready = !hold_valid;
    assign tone      = ACC_W'(tone_inc(32'(hold_sym), F0_INC, F_STEP));

    // The holding register can refill during the symbol that just drained it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            hold_valid <= 1'b0;
            hold_sym   <= '0;
        end else begin
            state <= state_next;
            if (sym_valid && sym_ready) begin
                hold_valid <= 1'b1;
                hold_sym   <= sym_data;
            end else if (load) begin
                hold_valid <= 1'b0;
            end
            if (load || clear) begin
                cnt <= '0;
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        clear      = 1'b0;
        busy       = 1'b0;
        clk1       = 1'b0;
        underrun   = 1'b0;
        case (state)
            IDLE: begin
                if (enable && hold_valid) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                clk1 = (cnt < CNT_HALF);
                if (cnt == CNT_LAST) begin
                    if (enable && hold_valid) begin
                        load = 1'b1;
                    end else begin
                        clear      = 1'b1;
                        underrun   = enable;
                        state_next = IDLE;
                    end
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    mfsk_nco #(
        .ACC_W(ACC_W)
    ) u_nco (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .advance(advance),
        .clear  (clear),
        .tone   (tone),
        .shuchu (shuchu)
    );

endmodule

// File: tb/tb_mfsk_mod.sv
// tb/tb_mfsk_mod.sv - self-checking bench for mfsk_mod against a phase-arithmetic reference model
module tb_mfsk_mod;

`ifdef MFSK_CONT_PHASE_EN
    localparam int BPS  = 2;
    localparam int F0   = 8;
    localparam int STEP = 8;
`else
    localparam int BPS  = 1;
    localparam int F0   = 16;
    localparam int STEP = 16;
`endif
    localparam int ACC_W   = 8;
    localparam int SYM_DIV = 16;
    localparam int M       = 1 << BPS;
    localparam int HALF    = SYM_DIV / 2;
    localparam int MASK    = (1 << ACC_W) - 1;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           enable    = 1'b0;
    logic           sym_valid = 1'b0;
    logic [BPS-1:0] sym_data  = '0;
    logic           sym_ready;
    logic           shuchu;
    logic           clk1;
    logic           busy;
    logic           underrun;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mfsk_mod #(
        .ACC_W  (ACC_W),
        .BPS    (BPS),
        .SYM_DIV(SYM_DIV),
        .F0_INC (F0),
        .F_STEP (STEP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .sym_data (sym_data),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready),
        .shuchu   (shuchu),
        .clk1     (clk1),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    function automatic int tone(input int s);
        return F0 + s * STEP;
    endfunction

    // Output k of a symbol is the MSB of the phase after k+1 increments from its start phase.
    function automatic logic [4:0] run_vec(input int base, input int s, input int k,
                                           input bit un, input bit rdy);
        int ph;
        bit sh;
        bit c1;
        ph = (base + tone(s) * (k + 1)) & MASK;
        sh = ((ph >> (ACC_W - 1)) & 1) != 0;
        c1 = k < HALF;
        return {1'b1, c1, sh, un, rdy};
    endfunction

    function automatic int next_base(input int base, input int s);
`ifdef MFSK_CONT_PHASE_EN
        return (base + tone(s) * SYM_DIV) & MASK;
`else
        return 0 * (base + s);
`endif
    endfunction

    function automatic logic [4:0] obs();
        return {busy, clk1, shuchu, underrun, sym_ready};
    endfunction

    task automatic test_reset();
        logic [4:0] o;
        rst_n     = 1'b0;
        enable    = 1'b0;
        sym_valid = 1'b0;
        repeat (2) @(negedge clk);
        o = obs();
        total_cnt++;
        if (o !== 5'b00001) $display("FAIL reset_hold: busy,clk1,shuchu,underrun,ready = %b, expected 00001", o);
        else pass_cnt++;
        rst_n = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            o = obs();
            total_cnt++;
            if (o !== 5'b00001) $display("FAIL reset_idle cycle %0d: busy,clk1,shuchu,underrun,ready = %b, expected 00001", j, o);
            else pass_cnt++;
        end
    endtask

    task automatic test_stream(input string name, input int n, input int s0, input int s1,
                               input int s2, input bit rnd);
        int q[$];
        int bases[$];
        int idx = 0;
        bit can_hs = 1'b0;
        int c, i, k;
        logic [4:0] e, o;
        for (int t = 0; t < n; t++)
            q.push_back(rnd ? int'($urandom_range(0, M - 1)) : (t == 0 ? s0 : (t == 1 ? s1 : s2)));
        bases.push_back(0);
        for (int t = 1; t < n; t++) bases.push_back(next_base(bases[t-1], q[t-1]));
        enable = 1'b1;
        for (int j = 0; j < n * SYM_DIV + 6; j++) begin
            @(negedge clk);
            if (can_hs) idx++;
            if (j < 2) begin
                e = {4'b0000, 1'(j == 0)};
            end else if (j - 2 < n * SYM_DIV) begin
                c = j - 2;
                i = c / SYM_DIV;
                k = c % SYM_DIV;
                e = run_vec(bases[i], q[i], k, (i == n - 1) && (k == SYM_DIV - 1),
                            (k == 0) || (i >= n - 1));
            end else begin
                e = 5'b00001;
            end
            o = obs();
            total_cnt++;
            if (o !== e) $display("FAIL %s cycle %0d: busy,clk1,shuchu,underrun,ready = %b, expected %b", name, j, o, e);
            else pass_cnt++;
            sym_valid = (idx < n);
            sym_data  = (idx < n) ? BPS'(q[idx]) : '0;
            can_hs    = sym_valid && sym_ready;
        end
        sym_valid = 1'b0;
    endtask

    task automatic test_graceful_stop();
        int a, b, c, idx;
        bit can_hs;
        logic [4:0] e, o;
        a      = int'($urandom_range(0, M - 1));
        b      = int'($urandom_range(0, M - 1));
        idx    = 0;
        can_hs = 1'b0;
        enable = 1'b1;
        for (int j = 0; j < SYM_DIV + 8; j++) begin
            @(negedge clk);
            if (can_hs) idx++;
            c = j - 2;
            if (j < 2) e = {4'b0000, 1'(j == 0)};
            else if (c < SYM_DIV) e = run_vec(0, a, c, 1'b0, c == 0);
            else e = 5'b00000;
            o = obs();
            total_cnt++;
            if (o !== e) $display("FAIL stop cycle %0d: busy,clk1,shuchu,underrun,ready = %b, expected %b", j, o, e);
            else pass_cnt++;
            sym_valid = (idx < 2);
            sym_data  = BPS'((idx == 0) ? a : b);
            can_hs    = sym_valid && sym_ready;
            if (c == 5) enable = 1'b0;
        end
        sym_valid = 1'b0;
        enable    = 1'b1;
        for (int j = 0; j < SYM_DIV + 4; j++) begin
            @(negedge clk);
            e = (j < SYM_DIV) ? run_vec(0, b, j, j == SYM_DIV - 1, 1'b1) : 5'b00001;
            o = obs();
            total_cnt++;
            if (o !== e) $display("FAIL stop_resume cycle %0d: busy,clk1,shuchu,underrun,ready = %b, expected %b", j, o, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset();
        int b, idx;
        bit can_hs;
        logic [4:0] e, o;
        b      = int'($urandom_range(0, M - 1));
        idx    = 0;
        can_hs = 1'b0;
        enable = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (can_hs) idx++;
            if (j < 2) e = {4'b0000, 1'(j == 0)};
            else e = run_vec(0, 0, j - 2, 1'b0, j == 2);
            o = obs();
            total_cnt++;
            if (o !== e) $display("FAIL midrst_run cycle %0d: busy,clk1,shuchu,underrun,ready = %b, expected %b", j, o, e);
            else pass_cnt++;
            sym_valid = (idx < 2);
            sym_data  = BPS'((idx == 0) ? 0 : b);
            can_hs    = sym_valid && sym_ready;
        end
        sym_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        o = obs();
        total_cnt++;
        if (o !== 5'b00001) $display("FAIL midrst_async: busy,clk1,shuchu,underrun,ready = %b, expected 00001", o);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            o = obs();
            total_cnt++;
            if (o !== 5'b00001) $display("FAIL midrst_after cycle %0d: busy,clk1,shuchu,underrun,ready = %b, expected 00001", j, o);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_stream("single0", 1, 0, 0, 0, 1'b0);
        test_stream("b2b_011", 3, 0, 1, 1, 1'b0);
`ifdef MFSK_CONT_PHASE_EN
        test_stream("cpfsk_30", 2, 3, 0, 0, 1'b0);
`endif
        test_stream("b2b_rand", 6, 0, 0, 0, 1'b1);
        test_graceful_stop();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
